// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / load-store) arbiter in front of a single
// request/response memory port. One transaction in flight at a time:
// IDLE grants, REQ presents the registered request, WAIT takes the response.
// A fetch flushed while in flight still completes to memory but its
// response is swallowed.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the winner on
// contention (first contention after reset goes to fetch). Without it the
// load/store port always wins contention.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req_valid_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_req_ready_o,
    output logic                if_rsp_valid_o,

    input  logic                ls_req_valid_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic                ls_we_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_wmask_i,
    output logic                ls_req_ready_o,
    output logic                ls_rsp_valid_o,

    output logic [DATA_W-1:0]   rsp_rdata_o,
    input  logic                flush_i,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic                drop_q;
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_wmask_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_grant_q;
`endif

    logic if_cand;
    logic grant_if;
    logic grant_ls;
    logic rsp_fire;
    logic flush_if;

    // Grant decision: only in IDLE and never while reset is asserted.
    always_comb begin
        if_cand  = if_req_valid_i && !flush_i;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == ST_IDLE && rst_n) begin
            if (if_cand && ls_req_valid_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_grant_q == OWN_LS) begin
                    grant_if = 1'b1;
                end else begin
                    grant_ls = 1'b1;
                end
`else
                grant_ls = 1'b1;
`endif
            end else begin
                grant_if = if_cand;
                grant_ls = ls_req_valid_i;
            end
        end
    end

    assign flush_if = flush_i && (owner_q == OWN_IF);

    // Sequencer: latch the granted request, hold it until memory accepts, then wait for data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IF;
            drop_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q    <= OWN_LS;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    drop_q <= 1'b0;
                    if (grant_ls) begin
                        owner_q         <= OWN_LS;
                        mem_addr_q      <= ls_addr_i;
                        mem_we_q        <= ls_we_i;
                        mem_wdata_q     <= ls_wdata_i;
                        mem_wmask_q     <= ls_wmask_i;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q    <= OWN_LS;
`endif
                    end else if (grant_if) begin
                        owner_q         <= OWN_IF;
                        mem_addr_q      <= if_addr_i;
                        mem_we_q        <= 1'b0;
                        mem_wdata_q     <= '0;
                        mem_wmask_q     <= '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q    <= OWN_IF;
`endif
                    end
                end
                ST_REQ: begin
                    if (flush_if) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        drop_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (flush_if) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Response steering: same-cycle pass-through; a flushed fetch never reports.
    always_comb begin
        rsp_fire       = (state_q == ST_WAIT) && mem_rsp_valid_i;
        ls_rsp_valid_o = rsp_fire && (owner_q == OWN_LS);
        if_rsp_valid_o = rsp_fire && (owner_q == OWN_IF) && !drop_q && !flush_i;
    end

    assign if_req_ready_o  = grant_if;
    assign ls_req_ready_o  = grant_ls;
    assign rsp_rdata_o     = mem_rdata_i;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_we_o        = mem_we_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_wmask_o     = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter (default 64-bit widths). Honors ARB_ROUND_ROBIN_EN
// when defined for the build.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_v = 1'b0, flush = 1'b0, ls_v = 1'b0, ls_we = 1'b0;
    logic        mem_ready = 1'b0, mem_rsp = 1'b0;
    logic [63:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
    logic [7:0]  ls_wmask = '0;

    logic        if_rdy, if_rsp, ls_rdy, ls_rsp, mem_v, mem_we;
    logic [63:0] rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid_i(if_v), .if_addr_i(if_addr),
        .if_req_ready_o(if_rdy), .if_rsp_valid_o(if_rsp),
        .ls_req_valid_i(ls_v), .ls_addr_i(ls_addr), .ls_we_i(ls_we),
        .ls_wdata_i(ls_wdata), .ls_wmask_i(ls_wmask),
        .ls_req_ready_o(ls_rdy), .ls_rsp_valid_o(ls_rsp),
        .rsp_rdata_o(rdata), .flush_i(flush),
        .mem_req_valid_o(mem_v), .mem_req_ready_i(mem_ready),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_wmask_o(mem_wmask), .mem_rsp_valid_i(mem_rsp), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: at most one transaction in flight, which is
    // either waiting to be accepted by memory or waiting for its data.
    bit          m_busy, m_issued, m_owner_ls, m_drop, m_last_ls;
    logic [63:0] m_addr, m_wdata;
    bit          m_we;
    logic [7:0]  m_mask;

    logic        o_if_rdy, o_ls_rdy, o_mem_v, o_if_rsp, o_ls_rsp, o_we;
    logic [63:0] o_addr, o_rdata, o_wdata;
    logic [7:0]  o_mask;

    function automatic bit ls_wins_contention();
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_ls;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_busy = 0; m_issued = 0; m_drop = 0; m_owner_ls = 0; m_last_ls = 1;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit g_if, g_ls, fire, e_if_rsp, e_ls_rsp;
        #2;
        o_if_rdy = if_rdy; o_ls_rdy = ls_rdy; o_mem_v = mem_v; o_addr = mem_addr;
        o_we = mem_we; o_wdata = mem_wdata; o_mask = mem_wmask;
        o_if_rsp = if_rsp; o_ls_rsp = ls_rsp; o_rdata = rdata;
        g_ls = !m_busy && ls_v && !(if_v && !flush && !ls_wins_contention());
        g_if = !m_busy && if_v && !flush && !g_ls;
        fire = m_busy && m_issued && mem_rsp;
        e_ls_rsp = fire && m_owner_ls;
        e_if_rsp = fire && !m_owner_ls && !m_drop && !flush;
        check("if_req_ready", o_if_rdy, g_if);
        check("ls_req_ready", o_ls_rdy, g_ls);
        check("mem_req_valid", o_mem_v, m_busy && !m_issued);
        if (m_busy) begin
            check("mem_addr", o_addr, m_addr);
            check("mem_we", o_we, m_we);
            check("mem_wmask", o_mask, m_mask);
            if (m_owner_ls) check("mem_wdata", o_wdata, m_wdata);
        end
        check("if_rsp_valid", o_if_rsp, e_if_rsp);
        check("ls_rsp_valid", o_ls_rsp, e_ls_rsp);
        check("rsp_exclusive", o_if_rsp & o_ls_rsp, 0);
        if (e_if_rsp || e_ls_rsp) check("rsp_rdata", o_rdata, mem_rdata);
        @(posedge clk);
        if (!m_busy) begin
            if (g_if || g_ls) begin
                m_busy = 1; m_issued = 0; m_drop = 0;
                m_owner_ls = g_ls; m_last_ls = g_ls;
                m_addr  = g_ls ? ls_addr : if_addr;
                m_we    = g_ls && ls_we;
                m_wdata = ls_wdata;
                m_mask  = g_ls ? ls_wmask : 8'h00;
            end
        end else if (!m_issued) begin
            if (flush && !m_owner_ls) m_drop = 1;
            if (mem_ready) m_issued = 1;
        end else begin
            if (flush && !m_owner_ls) m_drop = 1;
            if (mem_rsp) begin m_busy = 0; m_drop = 0; end
        end
        #1;
    endtask

    task automatic clear_inputs();
        if_v = 0; ls_v = 0; flush = 0; ls_we = 0; mem_ready = 0; mem_rsp = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; if_v = 1; ls_v = 1; mem_rsp = 1;
        #1;
        check("rst_mem_valid", mem_v, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_if_ready", if_rdy, 0);
        check("rst_ls_ready", ls_rdy, 0);
        check("rst_if_rsp", if_rsp, 0);
        check("rst_ls_rsp", ls_rsp, 0);
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        clear_inputs(); mem_ready = 1; mem_rsp = 1;
        repeat (4) step();
        clear_inputs();
    endtask

    typedef struct {
        bit if_v; bit flush; bit ls_v; bit exp_if; bit exp_ls;
    } vec_t;
    vec_t vt[7];

    logic [3:0] exp_seq;
    logic [3:0] got_seq;
    int         ng;

    initial begin
        // Arbitration vectors from reset (last grant = LS).
        vt[0] = '{0, 0, 0, 0, 0};
        vt[1] = '{1, 0, 0, 1, 0};
        vt[2] = '{0, 0, 1, 0, 1};
        vt[3] = '{1, 1, 0, 0, 0};
        vt[4] = '{1, 1, 1, 0, 1};
`ifdef ARB_ROUND_ROBIN_EN
        vt[5] = '{1, 0, 1, 1, 0};
        vt[6] = '{1, 0, 1, 0, 1};
        exp_seq = 4'b1010;   // bit i = 1 means LS won grant i: IF,LS,IF,LS
`else
        vt[5] = '{1, 0, 1, 0, 1};
        vt[6] = '{1, 0, 1, 0, 1};
        exp_seq = 4'b1111;
`endif

        do_reset();

        for (int i = 0; i < 7; i++) begin
            drain();
            if_v = vt[i].if_v; flush = vt[i].flush; ls_v = vt[i].ls_v;
            if_addr = 64'h1000 + 64'(i); ls_addr = 64'h2000 + 64'(i);
            ls_wmask = 8'hFF;
            step();
            check($sformatf("vec%0d_if_ready", i), o_if_rdy, vt[i].exp_if);
            check($sformatf("vec%0d_ls_ready", i), o_ls_rdy, vt[i].exp_ls);
        end

        // Fetch with immediate memory: addr at N+1, data at N+2.
        do_reset();
        if_v = 1; if_addr = 64'h8000_0000; mem_ready = 1; mem_rsp = 1;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        step();
        check("fetch_grant", o_if_rdy, 1);
        if_v = 0;
        step();
        check("fetch_n1_valid", o_mem_v, 1);
        check("fetch_n1_addr", o_addr, 64'h8000_0000);
        check("fetch_n1_no_rsp", o_if_rsp, 0);
        step();
        check("fetch_n2_rsp", o_if_rsp, 1);
        check("fetch_n2_data", o_rdata, 64'h1234_5678_9ABC_DEF0);

        // Store with memory back-pressure for 3 cycles.
        clear_inputs();
        ls_v = 1; ls_we = 1; ls_addr = 64'h100; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        step();
        check("store_grant", o_ls_rdy, 1);
        ls_v = 0; ls_we = 0; ls_addr = 64'h5555; ls_wdata = 64'hFFFF_0000_FFFF_0000; ls_wmask = 8'hF0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("store_hold_valid", o_mem_v, 1);
            check("store_hold_addr", o_addr, 64'h100);
            check("store_hold_we", o_we, 1);
            check("store_hold_wdata", o_wdata, 64'hDEAD_BEEF);
            check("store_hold_wmask", o_mask, 8'h0F);
        end
        mem_ready = 1;
        step();
        mem_ready = 0;
        step();
        check("store_wait_no_rsp", o_ls_rsp, 0);
        mem_rsp = 1;
        step();
        check("store_rsp", o_ls_rsp, 1);
        check("store_rsp_not_if", o_if_rsp, 0);

        // Continuous contention over 4 transactions.
        do_reset();
        if_v = 1; ls_v = 1; mem_ready = 1; mem_rsp = 1;
        ng = 0; got_seq = '0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            step();
            if (o_if_rdy || o_ls_rdy) begin
                got_seq[ng] = o_ls_rdy;
                ng++;
            end
        end
        check("contend_grant_count", 64'(ng), 4);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("contend_grant%0d_is_ls", g), got_seq[g], exp_seq[g]);
        end

        // Flush pulse during WAIT of a fetch.
        drain();
        if_v = 1; if_addr = 64'h40; mem_ready = 1;
        step();
        if_v = 0;
        step();
        flush = 1;
        step();
        flush = 0; mem_rsp = 1;
        step();
        check("flush_if_rsp_dropped", o_if_rsp, 0);
        check("flush_ls_rsp_quiet", o_ls_rsp, 0);
        mem_rsp = 0;
        step();
        if_v = 1; if_addr = 64'h48;
        step();
        check("flush_next_grant", o_if_rdy, 1);
        if_v = 0; mem_rsp = 1; mem_rdata = 64'hCAFE;
        step();
        step();
        check("flush_next_rsp", o_if_rsp, 1);
        check("flush_next_data", o_rdata, 64'hCAFE);

        // Reset during WAIT, then a stray response.
        drain();
        ls_v = 1; ls_addr = 64'h300; mem_ready = 1;
        step();
        ls_v = 0;
        step();
        rst_n = 0;
        #1;
        check("midrst_mem_valid", mem_v, 0);
        check("midrst_mem_addr", mem_addr, 0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        mem_rsp = 1;
        step();
        check("stray_ls_rsp", o_ls_rsp, 0);
        check("stray_if_rsp", o_if_rsp, 0);
        if_v = 1;
        step();
        check("after_rst_idle_grant", o_if_rdy, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int r = 0; r < 600; r++) begin
            if_v      = 1'($urandom_range(0, 1));
            ls_v      = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 7) == 0);
            ls_we     = 1'($urandom_range(0, 1));
            if_addr   = {$urandom, $urandom};
            ls_addr   = {$urandom, $urandom};
            ls_wdata  = {$urandom, $urandom};
            ls_wmask  = 8'($urandom);
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rsp   = ($urandom_range(0, 2) != 0);
            mem_rdata = {$urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
